mod_n_updown_counter: RTL and testbench
=======================================

# mod_n_updown_counter

Parametrised synchronous up/down modulo-N binary counter, the generalised successor of the team's 4-bit 74LS163-style counter. It adds configurable width and modulus, a direction input, clamped parallel load, a compare-match flag and a registered wrap pulse. ENP/ENT/RCO remain cascade-compatible. It serves as the generic timebase/divider primitive for timer, prescaler and sequencing logic.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32
- MODULUS, 16, count modulus N; legal range 2..2^WIDTH; MAX = MODULUS-1
- CLK  input  1  clock; all state changes on rising edge
- CLR  input  1  reset, synchronous, active-high; overrides all other inputs
- D  input  WIDTH  parallel load value
- LOAD_n  input  1  synchronous parallel load, active-low
- ENP  input  1  count enable, parallel
- ENT  input  1  count enable, trickle; also gates RCO
- UP  input  1  direction: 1 = count up, 0 = count down
- CMP  input  WIDTH  compare value for MATCH
- Q  output  WIDTH  counter value, registered
- RCO  output  1  ripple carry / borrow out, combinational
- MATCH  output  1  Q == CMP, combinational
- WRAP  output  1  one-cycle registered pulse after a terminal-count rollover

## Operation
- Priority per rising edge of CLK: CLR, then LOAD_n, then count, then hold.
- CLR = 1: Q <= 0, WRAP <= 0.
- LOAD_n = 0 (CLR = 0): Q <= D if D <= MAX, else Q <= MAX (clamp). Enables are ignored. WRAP <= 0.
- Count condition: LOAD_n = 1 & ENP = 1 & ENT = 1.
  - UP = 1: Q <= (Q == MAX) ? 0 : Q+1.
  - UP = 0: Q <= (Q == 0) ? MAX : Q-1.
- No count (either enable low): Q holds, WRAP <= 0.
- WRAP <= 1 only on an edge where a count step takes Q from MAX to 0 (up) or from 0 to MAX (down). Otherwise WRAP <= 0.
- Terminal state TC = (UP & Q == MAX) | (~UP & Q == 0).
- RCO = ENT & TC, independent of ENP, LOAD_n and CLK. A cascade is built by tying the next stage's ENT to this stage's RCO.
- MATCH = (Q == CMP). It is full-width and is not clamped against MAX.
- Arithmetic is WIDTH bits unsigned. When MODULUS = 2^WIDTH, wrap is the natural overflow. When MODULUS < 2^WIDTH, no value above MAX is reachable by counting or loading.
- UP may change on any cycle; the new direction applies from the next counting edge. No transient is allowed on Q.
- Parameter check: an illegal WIDTH or MODULUS causes an elaboration-time error.

## Timing
- Reset values: Q = 0, WRAP = 0. RCO = ENT & ~UP (Q = 0 is terminal when counting down). MATCH = (CMP == 0).
- Latency of load, count and clear: 1 cycle (result visible after the edge).
- WRAP is asserted for exactly one cycle, on the cycle after Q rolls over, i.e. coincident with Q = 0 (up) or Q = MAX (down). It never lasts more than one cycle, even when rollovers are back-to-back (MODULUS = 2 gives alternating cycles).
- RCO and MATCH follow Q and the inputs combinationally within the same cycle.
- CLR asserted while counting: takes effect at that edge, and any WRAP that would have been generated is suppressed. On release, counting resumes from 0 at the first edge with CLR = 0.
- Simultaneous LOAD_n = 0 and terminal count with enables high: the load wins and no WRAP is generated.
- Simultaneous CLR = 1 and LOAD_n = 0: the clear wins.

## Test plan
- Reset/count with WIDTH=4, MODULUS=10: CLR 1 cycle, then ENP=ENT=LOAD_n=UP=1 for 12 cycles -> Q = 0,1..9,0,1,2. WRAP is high only in the cycle where Q returns to 0. RCO is high only when Q = 9.
- Down count with WIDTH=4, MODULUS=10: load D=2 with UP=0, enables high for 4 cycles -> Q = 2,1,0,9,8. RCO is high at Q = 0. WRAP is high with Q = 9.
- Load clamp and priority with MODULUS=10: D=13 with LOAD_n=0 -> Q = 9. D=5 with LOAD_n=0 and CLR=1 -> Q = 0. D=5 with LOAD_n=0 while ENP=0 -> Q = 5.
- Enable gating: Q=9, UP=1, ENT=1, ENP=0 for 3 cycles -> Q holds 9, RCO = 1, WRAP = 0. Then ENT=0 -> RCO = 0, Q holds.
- Cascade of two instances, WIDTH=4, MODULUS=16: low RCO drives high ENT, both ENP=1 -> the 8-bit value increments 0x0F -> 0x10 and 0xFF -> 0x00. The high-stage WRAP fires only at the 0xFF -> 0x00 edge.
- Mid-operation events with MODULUS=16: CMP=7, counting up from 5 -> MATCH is high only while Q = 7. Flip UP to 0 at Q=8 -> the sequence is 8,7,6. CLR at Q=15 with enables high -> Q = 0 and WRAP = 0.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Synchronous up/down modulo-N counter, cascade-compatible successor of the
// 74LS163-style counter: clamped parallel load, compare match and wrap pulse.
module mod_n_updown_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] CMP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             MATCH,
  output logic             WRAP
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH must be in 2..32");
  end

  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             tc;

  // Terminal state depends on direction, so RCO tracks UP without a clock.
  assign tc = UP ? (q_q == MAX) : (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!LOAD_n) begin
      q_d = (D > MAX) ? MAX : D;
    end else if (ENP && ENT) begin
      wrap_d = tc;
      if (UP) begin
        q_d = tc ? '0 : q_q + WIDTH'(1);
      end else begin
        q_d = tc ? MAX : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q     = q_q;
  assign WRAP  = wrap_q;
  assign RCO   = ENT & tc;
  assign MATCH = (q_q == CMP);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench: mod-10 and mod-2 counters plus a two-stage mod-16 cascade
// checked against an arithmetic reference model.
module tb_mod_n_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared controls for the mod-10 (A) and mod-2 (B) instances
  logic       a_clr = 1'b1, a_load_n = 1'b1, a_enp = 1'b0, a_ent = 1'b0, a_up = 1'b1;
  logic [3:0] a_d = '0, a_cmp = '0;
  logic [3:0] a_q;
  logic       a_rco, a_match, a_wrap;
  logic [2:0] b_q;
  logic       b_rco, b_match, b_wrap;

  // Cascade controls
  logic       c_clr = 1'b1, c_load_n = 1'b1, c_enp = 1'b0, c_ent = 1'b0, c_up = 1'b1;
  logic [7:0] c_d = '0;
  logic [3:0] c_cmp = '0;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco, lo_match, hi_match, lo_wrap, hi_wrap;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .CLK(clk), .CLR(a_clr), .D(a_d), .LOAD_n(a_load_n), .ENP(a_enp), .ENT(a_ent),
    .UP(a_up), .CMP(a_cmp), .Q(a_q), .RCO(a_rco), .MATCH(a_match), .WRAP(a_wrap));

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(2)) u_b (
    .CLK(clk), .CLR(a_clr), .D(a_d[2:0]), .LOAD_n(a_load_n), .ENP(a_enp), .ENT(a_ent),
    .UP(a_up), .CMP(a_cmp[2:0]), .Q(b_q), .RCO(b_rco), .MATCH(b_match), .WRAP(b_wrap));

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
    .CLK(clk), .CLR(c_clr), .D(c_d[3:0]), .LOAD_n(c_load_n), .ENP(c_enp), .ENT(c_ent),
    .UP(c_up), .CMP(c_cmp), .Q(lo_q), .RCO(lo_rco), .MATCH(lo_match), .WRAP(lo_wrap));

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
    .CLK(clk), .CLR(c_clr), .D(c_d[7:4]), .LOAD_n(c_load_n), .ENP(c_enp), .ENT(lo_rco),
    .UP(c_up), .CMP(c_cmp), .Q(hi_q), .RCO(hi_rco), .MATCH(hi_match), .WRAP(hi_wrap));

  typedef struct {
    int   aq; logic aw, arco, amatch;
    int   bq; logic bw, brco, bmatch;
    int   cv; logic lw, hw, lrco, hrco, lm, hm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: plain integers, cascade treated as one 8-bit value
  int   qa = 0, qb = 0, cv = 0;
  logic wa = 1'b0, wb = 1'b0, lw = 1'b0, hw = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_step(input int m, input int q, input logic clr, input logic ld_n,
                                   input logic en, input logic up, input int d,
                                   output int qn, output logic w);
    qn = q;
    w  = 1'b0;
    if (clr) qn = 0;
    else if (!ld_n) qn = (d > m - 1) ? m - 1 : d;
    else if (en) begin
      if (up) begin w = (q == m - 1); qn = (q + 1) % m; end
      else    begin w = (q == 0);     qn = (q + m - 1) % m; end
    end
  endfunction

  // Expects are pushed for the present state under the inputs just driven,
  // then the model advances across the coming edge.
  task automatic cycle();
    exp_t e;
    logic lw_n;
    e.aq = qa; e.aw = wa;
    e.arco = a_ent & (a_up ? (qa == 9) : (qa == 0));
    e.amatch = (qa == int'(a_cmp));
    e.bq = qb; e.bw = wb;
    e.brco = a_ent & (a_up ? (qb == 1) : (qb == 0));
    e.bmatch = (qb == int'(a_cmp[2:0]));
    e.cv = cv; e.lw = lw; e.hw = hw;
    e.lrco = c_ent & (c_up ? (cv % 16 == 15) : (cv % 16 == 0));
    e.hrco = e.lrco & (c_up ? (cv / 16 == 15) : (cv / 16 == 0));
    e.lm = (cv % 16 == int'(c_cmp));
    e.hm = (cv / 16 == int'(c_cmp));
    sb.push_back(e);
    ref_step(10, qa, a_clr, a_load_n, a_enp & a_ent, a_up, int'(a_d), qa, wa);
    ref_step(2, qb, a_clr, a_load_n, a_enp & a_ent, a_up, int'(a_d[2:0]), qb, wb);
    lw_n = !c_clr & c_load_n & c_enp & c_ent & (c_up ? (cv % 16 == 15) : (cv % 16 == 0));
    ref_step(256, cv, c_clr, c_load_n, c_enp & c_ent, c_up, int'(c_d), cv, hw);
    lw = lw_n;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("a_q", int'(a_q), e.aq);
        chk("a_wrap", int'(a_wrap), int'(e.aw));
        chk("a_rco", int'(a_rco), int'(e.arco));
        chk("a_match", int'(a_match), int'(e.amatch));
        chk("b_q", int'(b_q), e.bq);
        chk("b_wrap", int'(b_wrap), int'(e.bw));
        chk("b_rco", int'(b_rco), int'(e.brco));
        chk("b_match", int'(b_match), int'(e.bmatch));
        chk("casc_q", int'({hi_q, lo_q}), e.cv);
        chk("lo_wrap", int'(lo_wrap), int'(e.lw));
        chk("hi_wrap", int'(hi_wrap), int'(e.hw));
        chk("lo_rco", int'(lo_rco), int'(e.lrco));
        chk("hi_rco", int'(hi_rco), int'(e.hrco));
        chk("lo_match", int'(lo_match), int'(e.lm));
        chk("hi_match", int'(hi_match), int'(e.hm));
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    a_clr = 1'b0;
    c_clr = 1'b0;

    // Mod-10 clear then count up through a rollover
    a_clr = 1'b1; cycle();
    a_clr = 1'b0; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1; a_load_n = 1'b1;
    repeat (12) cycle();
    // Load 2 and count down through zero
    a_load_n = 1'b0; a_d = 4'd2; a_up = 1'b0; cycle();
    a_load_n = 1'b1; repeat (5) cycle();
    // Clamp, clear-over-load, load with enables off
    a_load_n = 1'b0; a_d = 4'd13; cycle();
    a_d = 4'd5; a_clr = 1'b1; cycle();
    a_clr = 1'b0; a_enp = 1'b0; cycle();
    // Hold at terminal count with ENP low, then drop ENT
    a_d = 4'd9; cycle();
    a_load_n = 1'b1; a_up = 1'b1; a_ent = 1'b1; repeat (3) cycle();
    a_ent = 1'b0; repeat (2) cycle();
    // Load at terminal count with enables high: load wins
    a_enp = 1'b1; a_ent = 1'b1; a_load_n = 1'b0; a_d = 4'd4; cycle();
    a_load_n = 1'b1; cycle();

    // Cascade: 0x0F->0x10 and 0xFF->0x00
    c_enp = 1'b1; c_ent = 1'b1; c_up = 1'b1;
    c_load_n = 1'b0; c_d = 8'h0E; cycle();
    c_load_n = 1'b1; repeat (3) cycle();
    c_load_n = 1'b0; c_d = 8'hFE; cycle();
    c_load_n = 1'b1; repeat (3) cycle();
    // Compare match, direction flip, clear at terminal count
    c_cmp = 4'd7; c_load_n = 1'b0; c_d = 8'h05; cycle();
    c_load_n = 1'b1; repeat (3) cycle();
    c_up = 1'b0; repeat (3) cycle();
    c_up = 1'b1; c_load_n = 1'b0; c_d = 8'h3D; cycle();
    c_load_n = 1'b1; repeat (2) cycle();
    c_clr = 1'b1; cycle();
    c_clr = 1'b0; repeat (2) cycle();
    // Down-count borrow across the stage boundary
    c_up = 1'b0; c_load_n = 1'b0; c_d = 8'h10; cycle();
    c_load_n = 1'b1; repeat (2) cycle();

    for (int i = 0; i < 400; i++) begin
      a_clr    = ($urandom_range(0, 31) == 0);
      a_load_n = ($urandom_range(0, 11) != 0);
      a_enp    = ($urandom_range(0, 4) != 0);
      a_ent    = ($urandom_range(0, 4) != 0);
      a_up     = ($urandom_range(0, 3) != 0);
      a_d      = 4'($urandom_range(0, 15));
      a_cmp    = 4'($urandom_range(0, 15));
      c_clr    = ($urandom_range(0, 63) == 0);
      c_load_n = ($urandom_range(0, 15) != 0);
      c_enp    = ($urandom_range(0, 5) != 0);
      c_ent    = ($urandom_range(0, 5) != 0);
      c_up     = ($urandom_range(0, 2) != 0);
      c_d      = 8'($urandom_range(0, 255));
      c_cmp    = 4'($urandom_range(0, 15));
      cycle();
    end

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
